// File: rtl/imem_loader_if.sv
// Byte-stream, imem write-port and core-control signals of the instruction memory loader.
// The slave modport is the loader; the master modport is whatever feeds it the program image.
interface imem_loader_if #(
    parameter int WIDTH = 32,
    parameter int INDEX = 6
) ();
    logic               start_in;
    logic [INDEX:0]     word_count_in;
    logic               byte_valid_in;
    logic [7:0]         byte_in;
    logic               byte_ready_out;
    logic               imem_we_out;
    logic [INDEX-1:0]   imem_addr_out;
    logic [WIDTH-1:0]   imem_data_out;
    logic               core_nrst_out;
    logic               busy_out;
    logic               done_out;
    logic [WIDTH-1:0]   checksum_out;

    modport slave (
        input  start_in, word_count_in, byte_valid_in, byte_in,
        output byte_ready_out, imem_we_out, imem_addr_out, imem_data_out,
        output core_nrst_out, busy_out, done_out, checksum_out
    );

    modport master (
        output start_in, word_count_in, byte_valid_in, byte_in,
        input  byte_ready_out, imem_we_out, imem_addr_out, imem_data_out,
        input  core_nrst_out, busy_out, done_out, checksum_out
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a byte-serial program image into imem as little-endian 32-bit words at
// consecutive addresses from 0, holding the core in reset until the image is complete.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int INDEX = 6
) (
    input  logic          clk_in,
    input  logic          rst_in,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [INDEX:0] DEPTH    = {1'b1, {INDEX{1'b0}}};
    localparam logic [INDEX:0] ONE_WORD = {{INDEX{1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] insert_byte(input logic [WIDTH-1:0] word,
                                                     input logic [1:0]       lane,
                                                     input logic [7:0]       data);
        logic [WIDTH-1:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = data;
        return res;
    endfunction

    state_t           state_q, state_d;
    logic             byte_ready_q, byte_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [INDEX-1:0] imem_addr_q, imem_addr_d;
    logic [WIDTH-1:0] imem_data_q, imem_data_d;
    logic             core_nrst_q, core_nrst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] checksum_q, checksum_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [1:0]       lane_q, lane_d;
    logic [INDEX:0]   left_q, left_d;
    logic [INDEX-1:0] addr_cnt_q, addr_cnt_d;
    logic [WIDTH-1:0] word_ins_s;
    logic             accept_s;

    assign word_ins_s = insert_byte(word_q, lane_q, bus.byte_in);
    assign accept_s   = bus.byte_valid_in && byte_ready_q;

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d      = state_q;
        byte_ready_d = byte_ready_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_data_d  = imem_data_q;
        core_nrst_d  = core_nrst_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        checksum_d   = checksum_q;
        word_d       = word_q;
        lane_d       = lane_q;
        left_d       = left_q;
        addr_cnt_d   = addr_cnt_q;
        case (state_q)
            IDLE: begin
                byte_ready_d = 1'b0;
                busy_d       = 1'b0;
                core_nrst_d  = 1'b1;
                if (bus.start_in) begin
                    checksum_d = {WIDTH{1'b0}};
                    addr_cnt_d = {INDEX{1'b0}};
                    lane_d     = 2'd0;
                    word_d     = {WIDTH{1'b0}};
                    if (bus.word_count_in > DEPTH) begin
                        left_d = DEPTH;
                    end else begin
                        left_d = bus.word_count_in;
                    end
                    if (bus.word_count_in == {(INDEX+1){1'b0}}) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = COLLECT;
                        core_nrst_d  = 1'b0;
                        busy_d       = 1'b1;
                        byte_ready_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s) begin
                    word_d = word_ins_s;
                    lane_d = lane_q + 2'd1;
                    // The write strobe is launched with the last byte so it is visible during WRITE.
                    if (lane_q == 2'd3) begin
                        state_d      = WRITE;
                        byte_ready_d = 1'b0;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = addr_cnt_q;
                        imem_data_d  = word_ins_s;
                        checksum_d   = checksum_q ^ word_ins_s;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            WRITE: begin
                addr_cnt_d = addr_cnt_q + {{(INDEX-1){1'b0}}, 1'b1};
                left_d     = left_q - ONE_WORD;
                lane_d     = 2'd0;
                if (left_q == ONE_WORD) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    core_nrst_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    state_d      = COLLECT;
                    byte_ready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                byte_ready_d = 1'b0;
                busy_d       = 1'b0;
                core_nrst_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {INDEX{1'b0}};
            imem_data_q  <= {WIDTH{1'b0}};
            core_nrst_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            checksum_q   <= {WIDTH{1'b0}};
            word_q       <= {WIDTH{1'b0}};
            lane_q       <= 2'd0;
            left_q       <= {(INDEX+1){1'b0}};
            addr_cnt_q   <= {INDEX{1'b0}};
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_data_q  <= imem_data_d;
            core_nrst_q  <= core_nrst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            checksum_q   <= checksum_d;
            word_q       <= word_d;
            lane_q       <= lane_d;
            left_q       <= left_d;
            addr_cnt_q   <= addr_cnt_d;
        end
    end

    assign bus.byte_ready_out = byte_ready_q;
    assign bus.imem_we_out    = imem_we_q;
    assign bus.imem_addr_out  = imem_addr_q;
    assign bus.imem_data_out  = imem_data_q;
    assign bus.core_nrst_out  = core_nrst_q;
    assign bus.busy_out       = busy_q;
    assign bus.done_out       = done_q;
    assign bus.checksum_out   = checksum_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: loads push expected writes and checksums,
// a negedge monitor pops and compares them whenever the DUT writes or signals done.
module tb_imem_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if #(.WIDTH(32), .INDEX(6)) bus ();
    imem_loader #(.WIDTH(32), .INDEX(6)) dut (.clk_in(clk), .rst_in(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_ck[$];
    logic [31:0] words_mem [0:127];
    wr_t         mon_w;
    logic [31:0] mon_ck;
    int n_checks = 0, n_fail = 0;
    int we_count = 0, done_count = 0, acc_count = 0, nrst_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on writes and done pulses, plus activity counters.
    always @(negedge clk) begin
        if (bus.imem_we_out === 1'b1) begin
            we_count++;
            check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                mon_w = exp_wr.pop_front();
                check("write_addr", 32'(bus.imem_addr_out), 32'(mon_w.a));
                check("write_data", bus.imem_data_out, mon_w.d);
            end
        end
        if (bus.done_out === 1'b1) begin
            done_count++;
            check("done_expected", 32'(exp_ck.size() != 0), 32'd1);
            if (exp_ck.size() != 0) begin
                mon_ck = exp_ck.pop_front();
                check("checksum", bus.checksum_out, mon_ck);
            end
        end
        if (bus.byte_valid_in === 1'b1 && bus.byte_ready_out === 1'b1) acc_count++;
        if (bus.core_nrst_out === 1'b0) nrst_low++;
    end

    task automatic pulse_start(input logic [6:0] wc);
        repeat (2) begin @(posedge clk); #1; end
        bus.start_in      = 1'b1;
        bus.word_count_in = wc;
        @(posedge clk); #1;
        bus.start_in      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.byte_valid_in = 1'b1;
        bus.byte_in       = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.byte_ready_out === 1'b1) break;
        end
        check("byte_ready", 32'(bus.byte_ready_out), 32'd1);
        @(posedge clk); #1;
        bus.byte_valid_in = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int k = 0; k < budget && done_count == d0; k++) begin
            @(negedge clk); #1;
        end
        check("done_pulses", 32'(done_count - d0), 32'd1);
    endtask

    task automatic run_load(input logic [6:0] wc, input int n, input int gap,
                            input logic [31:0] ck, input int mid_start);
        int we0, acc0, d0;
        wr_t w;
        we0 = we_count; acc0 = acc_count; d0 = done_count;
        for (int i = 0; i < n; i++) begin
            w.a = 6'(i);
            w.d = words_mem[i];
            exp_wr.push_back(w);
        end
        exp_ck.push_back(ck);
        pulse_start(wc);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (i == mid_start && b == 0) begin
                    bus.start_in      = 1'b1;
                    bus.word_count_in = 7'd5;
                end
                send_byte(words_mem[i][8*b +: 8], gap);
                bus.start_in = 1'b0;
            end
        end
        wait_done(d0, 400);
        check("write_count", 32'(we_count - we0), 32'(n));
        check("bytes_accepted", 32'(acc_count - acc0), 32'(4 * n));
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("busy_after_done", 32'(bus.busy_out), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_in      = 1'b0;
        bus.word_count_in = 7'd0;
        bus.byte_valid_in = 1'b0;
        bus.byte_in       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_byte_ready", 32'(bus.byte_ready_out), 32'd0);
        check("rst_we", 32'(bus.imem_we_out), 32'd0);
        check("rst_core_nrst", 32'(bus.core_nrst_out), 32'd1);
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_done", 32'(bus.done_out), 32'd0);
        check("rst_checksum", bus.checksum_out, 32'h0);

        // Single word, consecutive bytes.
        words_mem[0] = 32'h00500013;
        nrst_low = 0;
        run_load(7'd1, 1, 0, 32'h00500013, -1);
        repeat (2) @(posedge clk);
        #1;
        check("single_nrst_low_cycles", 32'(nrst_low), 32'd5);
        check("hold_data", bus.imem_data_out, 32'h00500013);
        check("hold_addr", 32'(bus.imem_addr_out), 32'd0);

        // Reset after two bytes of the first word aborts the load.
        pulse_start(7'd2);
        send_byte(8'h13, 0);
        send_byte(8'h57, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_byte_ready", 32'(bus.byte_ready_out), 32'd0);
        check("mid_rst_we", 32'(bus.imem_we_out), 32'd0);
        check("mid_rst_core_nrst", 32'(bus.core_nrst_out), 32'd1);
        check("mid_rst_busy", 32'(bus.busy_out), 32'd0);
        check("mid_rst_data", bus.imem_data_out, 32'h0);
        check("mid_rst_checksum", bus.checksum_out, 32'h0);
        rst_n = 1'b1;
        words_mem[0] = 32'hDDCCBBAA;
        run_load(7'd1, 1, 0, 32'hDDCCBBAA, -1);

        // Gapped stream of three words.
        words_mem[0] = 32'h11111111;
        words_mem[1] = 32'h22222222;
        words_mem[2] = 32'h33333333;
        run_load(7'd3, 3, 1, 32'h00000000, -1);

        // Zero count: done only, core never held in reset.
        nrst_low = 0;
        run_load(7'd0, 0, 0, 32'h00000000, -1);
        repeat (2) @(posedge clk);
        #1;
        check("zero_nrst_low_cycles", 32'(nrst_low), 32'd0);

        // Full depth with a start pulse mid-load, then an over-range count.
        for (int i = 0; i < 64; i++) words_mem[i] = 32'(i);
        run_load(7'd64, 64, 0, 32'h00000000, 10);
        check("full_last_addr", 32'(bus.imem_addr_out), 32'd63);
        run_load(7'd100, 64, 0, 32'h00000000, -1);
        check("clamp_last_addr", 32'(bus.imem_addr_out), 32'd63);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
